// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding, default width
// and the carry-generation helper used by the per-bit adder.
package adder_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder; the serial adder reuses a single instance every cycle.
module full_adder_1bit
    import adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = maj3(a, b, c_in);

endmodule

// File: rtl/serial_adder_16bit.sv
// Bit-serial adder: one operand bit per cycle, LSB first, with the result and
// carry-out published only once all WIDTH bits have been processed.
module serial_adder_16bit
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] d_a,
    input  logic [WIDTH-1:0] d_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic fa_s;
    logic fa_cout;

    full_adder_1bit u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c_in  (c_q),
        .s     (fa_s),
        .c_out (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = d_a;
                    b_d     = d_b;
                    c_d     = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_cout;
                acc_d = {fa_s, acc_q[WIDTH-1:1]};
                // The counter parks at the last bit; the state change ends the run.
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {fa_s, acc_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_16bit.sv
// Self-checking bench for serial_adder_16bit: scoreboarded directed cases,
// lockout, abort, back-to-back timing and a subtract/add round trip.
module tb_serial_adder_16bit;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] d_a;
    logic [W-1:0] d_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int   testCount = 0;
    int   failCount = 0;
    int   cycle = 0;
    int   startCycle = 0;
    exp_t sb[$];

    serial_adder_16bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .d_a   (d_a),
        .d_b   (d_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                                 input logic [W-1:0] expSum, input logic expCout, input bit track);
        exp_t e;
        @(negedge clk);
        d_a   = a;
        d_b   = b;
        cin   = ci;
        start = 1'b1;
        if (track) begin
            e.sum  = expSum;
            e.cout = expCout;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        startCycle = cycle;
        checkValue("busyAfterStart", {31'b0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic checkOutput();
        int   guard;
        exp_t e;
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkValue("doneSeen", {31'b0, done}, 32'd1);
        checkValue("doneLatency", cycle - startCycle, W);
        checkValue("busyInDone", {31'b0, busy}, 32'd1);
        if (sb.size() == 0) begin
            e.sum  = 'x;
            e.cout = 1'bx;
        end else begin
            e = sb.pop_front();
        end
        checkValue("sum", {16'b0, sum}, {16'b0, e.sum});
        checkValue("cout", {31'b0, cout}, {31'b0, e.cout});
        @(posedge clk);
        #1;
        checkValue("donePulseWidth", {31'b0, done}, 32'd0);
        checkValue("busyBackToIdle", {31'b0, busy}, 32'd0);
        checkValue("sumHeld", {16'b0, sum}, {16'b0, e.sum});
    endtask

    initial begin
        int doneSeen;
        int firstDone;
        int secondDone;
        int guard;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] diff;

        rst   = 1'b1;
        start = 1'b0;
        d_a   = '0;
        d_b   = '0;
        cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkValue("resetSum", {16'b0, sum}, 32'd0);
        checkValue("resetCout", {31'b0, cout}, 32'd0);
        checkValue("resetDone", {31'b0, done}, 32'd0);
        checkValue("resetBusy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1);
        checkOutput();
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1);
        checkOutput();
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1);
        checkOutput();

        // Lockout: a second start mid-run must not disturb the operation.
        applyStimulus(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1);
        repeat (4) @(negedge clk);
        checkValue("sumHeldMidRun", {16'b0, sum}, 32'h0000FFFF);
        start = 1'b1;
        d_a   = 16'hAAAA;
        @(negedge clk);
        start = 1'b0;
        checkOutput();
        doneSeen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) doneSeen++;
        end
        checkValue("lockoutExtraDone", doneSeen, 0);

        // Abort: reset at RUN cycle 8 suppresses done and clears the result.
        applyStimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) doneSeen++;
        end
        checkValue("abortNoDone", doneSeen, 0);
        checkValue("abortSum", {16'b0, sum}, 32'd0);
        checkValue("abortCout", {31'b0, cout}, 32'd0);
        checkValue("abortBusy", {31'b0, busy}, 32'd0);
        applyStimulus(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1);
        checkOutput();

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        d_a   = 16'h0100;
        d_b   = 16'h0200;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        doneSeen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) doneSeen++;
        end
        checkValue("rstPriorityIgnored", doneSeen, 0);
        checkValue("rstPrioritySum", {16'b0, sum}, 32'd0);

        // Start held high: accepted operations every W+2 cycles.
        @(negedge clk);
        d_a   = 16'h0005;
        d_b   = 16'h0007;
        cin   = 1'b0;
        start = 1'b1;
        firstDone = -1;
        secondDone = -1;
        guard = 0;
        while (secondDone < 0 && guard < 80) begin
            @(posedge clk);
            #1;
            guard++;
            if (done === 1'b1) begin
                if (firstDone < 0) firstDone = cycle;
                else secondDone = cycle;
            end
        end
        @(negedge clk);
        start = 1'b0;
        checkValue("backToBackPeriod", secondDone - firstDone, W + 2);
        checkValue("backToBackSum", {16'b0, sum}, 32'h0000000C);
        repeat (4) @(negedge clk);

        // Round trip through the subtractor: (a - b) + b must give back a.
        for (int i = 0; i < 1000; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            diff = ra - rb;
            applyStimulus(diff, rb, 1'b0, ra, (rb > ra), 1);
            checkOutput();
        end

        checkValue("scoreboardEmpty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
